// File: rtl/alu_share_ctl_pkg.sv
// Shared definitions for the ALU sharing controller.
//   - ALU op select encodings and flag bit positions within flags_q
//   - Response FSM state type (EMPTY / FULL)
//   - Round-robin pointer increment helper
package alu_share_ctl_pkg;

  localparam int IDW = 2;

  localparam logic [1:0] ALU_SEL_PASSB = 2'b00;
  localparam logic [1:0] ALU_SEL_OR    = 2'b01;
  localparam logic [1:0] ALU_SEL_SCAN  = 2'b10;
  localparam logic [1:0] ALU_SEL_ADD   = 2'b11;

  localparam int FLAG_CF = 2;
  localparam int FLAG_AF = 1;
  localparam int FLAG_OF = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Next pointer after granting idx, wrapping modulo n.
  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + IDW'(1);
  endfunction

endpackage

// File: rtl/alu_share_ctl_rr_arb_n.sv
// NREQ-way round-robin picker.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle
//   en_i   : grant enable; when low, no grant is issued
//   gnt_o  : one-hot grant (or zero)
//   idx_o  : binary index of the grant (0 when no grant)
module rr_arb_n
  import alu_share_ctl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic found;

  // Walk the requesters starting at the pointer; the first valid one wins.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (en_i && !found && (i == j) && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctl.sv
// Shares one combinational ALU between NREQ requesters.
// Optional feature macro: ALU_LOCK_EN (adds req_lock and grant locking).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake; req_ready is the one-hot grant
//   req_a/req_b/req_sel        packed per-requester operands and op select
//   alu_a/alu_b/alu_sel        operands to the shared ALU (requester 0 when idle)
//   alu_out/alu_cf/af/of       ALU result and flags
//   rsp_valid/rsp_ready        registered response handshake
//   rsp_data/rsp_id            registered result and the requester it belongs to
//   flags_q                    {cf,af,of}, updated only by accepted adds
//   req_lock                   (ALU_LOCK_EN only) keep the grant for the next op
//   dbg_state                  response FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready depends combinationally on req_valid; ready never
// feeds back into valid. A requester holding valid without ready keeps its
// fields stable.
module alu_share_ctl
  import alu_share_ctl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_sel,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [1:0]        alu_sel,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_cf,
  input  logic              alu_af,
  input  logic              alu_of,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [2:0]        flags_q,
`ifdef ALU_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output state_e            dbg_state
);

  state_e         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [2:0]     flg_q, flg_d;

  logic            can_accept;
  logic            accept;
  logic            lock_hit;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign accept     = |gnt;

`ifdef ALU_LOCK_EN
  logic            lock_q, lock_d;
  logic [NREQ-1:0] lock_mask;
  logic            locked_valid;
  logic            gnt_lock;

  // The locked requester is the last one accepted, i.e. id_q.
  always_comb begin
    lock_mask    = '0;
    locked_valid = 1'b0;
    gnt_lock     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == id_q) begin
        lock_mask[i] = 1'b1;
        locked_valid = req_valid[i];
      end
      if (IDW'(i) == gidx) gnt_lock = req_lock[i];
    end
  end

  // Masking the request vector down to the locked requester makes the
  // arbiter pick it no matter where the pointer sits.
  assign lock_hit = lock_q && locked_valid;
  assign arb_req  = lock_hit ? (req_valid & lock_mask) : req_valid;

  always_comb begin
    lock_d = lock_q;
    if (lock_q && !locked_valid) lock_d = 1'b0;
    if (accept) lock_d = gnt_lock;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  assign lock_hit = 1'b0;
  assign arb_req  = req_valid;
`endif

  rr_arb_n #(.NREQ(NREQ)) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .en_i  (can_accept),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign req_ready = gnt;

  // gidx is 0 when nothing is granted, so the idle ALU sees requester 0.
  always_comb begin
    alu_a   = req_a[W-1:0];
    alu_b   = req_b[W-1:0];
    alu_sel = req_sel[1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gidx) begin
        alu_a   = req_a[i*W +: W];
        alu_b   = req_b[i*W +: W];
        alu_sel = req_sel[i*2 +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    flg_d   = flg_q;
    if (accept) begin
      // Drain and refill in the same cycle keeps the register FULL.
      state_d = ST_FULL;
      data_d  = alu_out;
      id_d    = gidx;
      if (!lock_hit) ptr_d = ptr_inc(gidx, NREQ);
      if (alu_sel == ALU_SEL_ADD) begin
        flg_d[FLAG_CF] = alu_cf;
        flg_d[FLAG_AF] = alu_af;
        flg_d[FLAG_OF] = alu_of;
      end
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      flg_q   <= flg_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign flags_q   = flg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_ctl.sv
module tb_alu_share_ctl;
  import alu_share_ctl_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_sel;
  logic [W-1:0]      alu_a, alu_b, alu_out;
  logic [1:0]        alu_sel;
  logic              alu_cf, alu_af, alu_of;
  logic              rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic [2:0]        flags_q;
  state_e            dbg_state;

  // Per-requester stimulus fields
  logic [W-1:0]    ta [NREQ];
  logic [W-1:0]    tbv[NREQ];
  logic [1:0]      ts [NREQ];
  logic [NREQ-1:0] tv, tl;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W]   = ta[i];
      req_b[i*W +: W]   = tbv[i];
      req_sel[i*2 +: 2] = ts[i];
    end
    req_valid = tv;
  end

  // Reference ALU: returns {cf,af,of,result}. Non-add ops report all flags
  // set so that a controller wrongly loading them is visible.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s);
    logic [32:0] sum;
    logic [4:0]  nib;
    logic [31:0] r;
    r = '0;
    case (s)
      2'b00: return {3'b111, b};
      2'b01: return {3'b111, a | b};
      2'b10: begin
        for (int i = 0; i < 32; i++) if (b[i]) r = i;
        return {3'b111, r};
      end
      default: begin
        sum = {1'b0, a} + {1'b0, b};
        nib = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        return {sum[32], nib[4], (a[31] == b[31]) && (sum[31] != a[31]), sum[31:0]};
      end
    endcase
  endfunction

  always_comb {alu_cf, alu_af, alu_of, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  alu_share_ctl #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_cf    (alu_cf),
    .alu_af    (alu_af),
    .alu_of    (alu_of),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .flags_q   (flags_q),
`ifdef ALU_LOCK_EN
    .req_lock  (tl),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [36:0] exp_q[$];   // {flags, id, data}
  bit          m_full;
  logic [W-1:0] m_data;
  logic [1:0]  m_id, m_ptr;
  logic [2:0]  m_flags;
  bit          m_lock;
  int          g_last;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_data = '0; m_id = '0; m_ptr = '0; m_flags = '0; m_lock = 0;
    exp_q.delete();
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle(input string tag);
    int gi;
    int j;
    bit hit;
    logic [NREQ-1:0] er;
    logic [34:0] r;
    logic [36:0] e;
    #2;
    gi  = -1;
    hit = 0;
    if (!m_full || rsp_ready) begin
      if (m_lock && tv[m_id]) begin
        gi  = int'(m_id);
        hit = 1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          j = (int'(m_ptr) + k) % NREQ;
          if (gi < 0 && tv[j]) gi = j;
        end
      end
    end
    er = '0;
    if (gi >= 0) er[gi] = 1'b1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(er));
    if (gi >= 0) begin
      r = alu_f(ta[gi], tbv[gi], ts[gi]);
      exp_q.push_back({(ts[gi] == 2'b11) ? r[34:32] : m_flags, 2'(gi), r[31:0]});
    end else begin
      chk({tag, " idle alu_a"}, 64'(alu_a), 64'(ta[0]));
    end
    @(posedge clk);
    #1;
    g_last = gi;
    if (gi >= 0) begin
      e = exp_q.pop_front();
      chk({tag, " rsp_data"}, 64'(rsp_data), 64'(e[31:0]));
      chk({tag, " rsp_id"}, 64'(rsp_id), 64'(e[33:32]));
      m_full = 1; m_data = e[31:0]; m_id = e[33:32]; m_flags = e[36:34];
      if (!hit) m_ptr = 2'((gi + 1) % NREQ);
`ifdef ALU_LOCK_EN
      m_lock = tl[gi];
`else
      m_lock = 0;
`endif
    end else begin
      if (m_lock && !tv[m_id]) m_lock = 0;
      if (m_full && rsp_ready) m_full = 0;
      if (m_full) begin
        chk({tag, " hold rsp_data"}, 64'(rsp_data), 64'(m_data));
        chk({tag, " hold rsp_id"}, 64'(rsp_id), 64'(m_id));
      end
    end
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(m_full));
    chk({tag, " flags_q"}, 64'(flags_q), 64'(m_flags));
  endtask

  // Asynchronous reset pulse asserted mid-cycle; returns at posedge+1.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, " flags_q"}, 64'(flags_q), 64'(0));
    chk({tag, " rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int id_tab[5];

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    tv = '0; tl = '0;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; ts[i] = '0; end
    model_reset();
    g_last = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_data", 64'(rsp_data), 64'(0));
    chk("reset rsp_id", 64'(rsp_id), 64'(0));
    chk("reset flags_q", 64'(flags_q), 64'(0));
    rst_n = 1'b1;

    // Single add with full carry
    ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'h1; ts[0] = 2'b11; tv = 2'b01;
    cycle("add");
    chk("add flags 110", 64'(flags_q), 64'(3'b110));
    chk("add data 0", 64'(rsp_data), 64'(0));

    // Reset while FULL, pointer at 1
    tv = '0;
    do_reset("rst_full");

    // Round robin: both valid, pointer restarted at 0 so requester 0 first
    ta[0] = 32'h10; tbv[0] = 32'h01; ts[0] = 2'b01;
    ta[1] = 32'h20; tbv[1] = 32'h02; ts[1] = 2'b01;
    tv = 2'b11;
    for (int c = 0; c < 4; c++) begin
      cycle("rr");
      chk("rr id alternates", 64'(rsp_id), 64'(c % 2));
    end

    // Backpressure: FULL with consumer stalled, requester 1 waiting
    tv = 2'b10; ta[1] = 32'h5; tbv[1] = 32'hA; ts[1] = 2'b00;
    rsp_ready = 1'b0;
    repeat (3) cycle("stall");
    rsp_ready = 1'b1;
    cycle("unstall");
    chk("unstall id 1", 64'(rsp_id), 64'(1));

    // Drain
    tv = '0;
    cycle("drain");

    // Flag hold: overflowing add then an OR
    ta[0] = 32'h7FFF_FFFF; tbv[0] = 32'h1; ts[0] = 2'b11; tv = 2'b01;
    cycle("add_of");
    chk("add_of flags 011", 64'(flags_q), 64'(3'b011));
    ta[0] = 32'h5; tbv[0] = 32'h2; ts[0] = 2'b01;
    cycle("or");
    chk("or data 7", 64'(rsp_data), 64'(7));
    chk("or flags hold", 64'(flags_q), 64'(3'b011));

    // Pass-b and bit-scan ops
    ta[0] = $urandom; tbv[0] = 32'h0001_0000; ts[0] = 2'b10;
    cycle("scan");
    ta[0] = $urandom; tbv[0] = $urandom; ts[0] = 2'b00;
    cycle("passb");
    tv = '0;
    cycle("idle");

    // Random traffic; fields change only when idle or just accepted
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!tv[i] || g_last == i) begin
          tv[i]  = 1'($urandom_range(0, 1));
          ta[i]  = $urandom;
          tbv[i] = $urandom;
          ts[i]  = 2'($urandom_range(0, 3));
        end
      end
      tl = NREQ'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    // Lock sequence from a clean pointer
    tv = '0; tl = '0; rsp_ready = 1'b1;
    do_reset("rst_lock");
`ifdef ALU_LOCK_EN
    id_tab = '{0, 0, 0, 1, 0};
`else
    id_tab = '{0, 1, 0, 1, 0};
`endif
    tv = 2'b11;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        ta[i] = $urandom; tbv[i] = $urandom; ts[i] = 2'b11;
      end
      tl = (c < 2) ? 2'b01 : 2'b00;
      cycle("lock");
      chk("lock id order", 64'(rsp_id), 64'(id_tab[c]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
